// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and default parameter values for the pipeline hazard controller.
// Consumers: pipe_hazard_ctrl (top) and mc_timer.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_t;

  localparam int DEF_STAGES      = 5;
  localparam int DEF_EX_STAGE    = 2;
  localparam int DEF_FLUSH_STAGE = 1;
  localparam int DEF_MC_W        = 6;

endpackage

// File: rtl/pipe_hazard_ctrl_mc_timer.sv
// Multi-cycle op timer: holds the EX stage for mc_len cycles, then pulses done.
//   state | meaning
//   IDLE  | no op in flight; a non-zero mc_len with mc_start requests a stall now
//   BUSY  | op still occupying EX; cnt counts the remaining stall cycles
//   DONE  | release cycle; done pulses, no request, mc_start ignored
module mc_timer
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MC_W = DEF_MC_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mc_start,
  input  logic [MC_W-1:0] mc_len,
  output logic            ex_req,
  output logic            busy,
  output logic            done
);

  mc_state_t       state;
  logic [MC_W-1:0] cnt;

  // The first stall cycle is the IDLE cycle that sees mc_start, so the
  // request there must be combinational.
  assign ex_req = ((state == IDLE) && mc_start && (mc_len != '0)) || (state == BUSY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (mc_start && (mc_len != '0)) begin
            if (mc_len > MC_W'(1)) begin
              state <= BUSY;
              cnt   <= mc_len - MC_W'(1);
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (cnt == MC_W'(1)) begin
            state <= DONE;
            cnt   <= '0;
            done  <= 1'b1;
          end else begin
            cnt  <= cnt - MC_W'(1);
            busy <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/bubble/flush controller with a multi-cycle EX timer.
// Optional stall-cycle performance counter enabled by `define PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int STAGES      = DEF_STAGES,
  parameter int EX_STAGE    = DEF_EX_STAGE,
  parameter int FLUSH_STAGE = DEF_FLUSH_STAGE,
  parameter int MC_W        = DEF_MC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stall_req,
  input  logic              mc_start,
  input  logic [MC_W-1:0]   mc_len,
  input  logic              flush_req,
  input  logic              cnt_clr,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] bubble,
  output logic              mc_busy,
  output logic              mc_done
);

  logic              ex_req;
  logic              flush_pend;
  logic              flush_act;
  logic              flush_blocked;
  logic              flush_apply;
  logic              acc;
  logic [STAGES-1:0] ex_vec;
  logic [STAGES-1:0] eff_req;
  logic [STAGES-1:0] sfx;
  logic [STAGES-1:0] bubble_raw;
  logic [STAGES-1:0] stall_c;
  logic [STAGES-1:0] bubble_c;

  mc_timer #(.MC_W(MC_W)) u_mc_timer (
    .clk      (clk),
    .rst      (rst),
    .mc_start (mc_start),
    .mc_len   (mc_len),
    .ex_req   (ex_req),
    .busy     (mc_busy),
    .done     (mc_done)
  );

  always_comb begin
    ex_vec           = '0;
    ex_vec[EX_STAGE] = ex_req;
  end

  assign eff_req = stall_req | ex_vec;

  // Stage k stalls iff some stage at or above k requests; the bubble lands
  // on the first stage above the highest requester.
  always_comb begin
    acc = 1'b0;
    sfx = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc    = acc | eff_req[k];
      sfx[k] = acc;
    end
    bubble_raw = '0;
    for (int k = 1; k < STAGES; k++) begin
      bubble_raw[k] = sfx[k-1] & ~sfx[k];
    end
  end

  assign flush_act     = flush_req | flush_pend;
  assign flush_blocked = sfx[FLUSH_STAGE];
  assign flush_apply   = flush_act & ~flush_blocked;

  // An applied flush leaves nothing stalled: stages >= FLUSH_STAGE have no
  // request by definition, and the younger ones are being squashed.
  always_comb begin
    stall_c  = sfx;
    bubble_c = bubble_raw;
    if (flush_apply) begin
      stall_c               = '0;
      bubble_c              = '0;
      bubble_c[FLUSH_STAGE] = 1'b1;
    end
  end

  assign stall  = rst ? stall_c  : '0;
  assign bubble = rst ? bubble_c : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_pend <= 1'b0;
    end else begin
      flush_pend <= flush_act & flush_blocked;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (cnt_clr) begin
      stall_cnt_q <= '0;
    end else if (stall[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (STAGES=5, EX_STAGE=2, FLUSH_STAGE=1).
// Counter checks are compiled in only when PIPE_PERF_CNT_EN is defined.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] stall_req;
  logic       mc_start;
  logic [5:0] mc_len;
  logic       flush_req;
  logic       cnt_clr;
  logic [4:0] stall;
  logic [4:0] bubble;
  logic       mc_busy;
  logic       mc_done;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  pipe_hazard_ctrl #(
    .STAGES(5), .EX_STAGE(2), .FLUSH_STAGE(1), .MC_W(6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall_req (stall_req),
    .mc_start  (mc_start),
    .mc_len    (mc_len),
    .flush_req (flush_req),
    .cnt_clr   (cnt_clr),
`ifdef PIPE_PERF_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .stall     (stall),
    .bubble    (bubble),
    .mc_busy   (mc_busy),
    .mc_done   (mc_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the middle of the next cycle; inputs change here, outputs are sampled 1ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; stall_req = 5'b11111; mc_start = 1'b1; mc_len = 6'd5;
    flush_req = 1'b1; cnt_clr = 1'b0;
    next_cycle(); #1;
    total++; if (stall !== 5'b0) begin bad++; $display("FAIL reset_stall got=%b exp=%b", stall, 5'b0); end
    total++; if (bubble !== 5'b0) begin bad++; $display("FAIL reset_bubble got=%b exp=%b", bubble, 5'b0); end
    total++; if (mc_busy !== 1'b0 || mc_done !== 1'b0) begin bad++; $display("FAIL reset_fsm got=%b%b exp=00", mc_busy, mc_done); end
`ifdef PIPE_PERF_CNT_EN
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", stall_cnt); end
`endif
    next_cycle();
    stall_req = '0; mc_start = 1'b0; mc_len = '0; flush_req = 1'b0;
    rst = 1'b1;
    next_cycle(); #1;
    total++; if (stall !== 5'b0 || bubble !== 5'b0) begin bad++; $display("FAIL post_reset got=%b/%b exp=00000/00000", stall, bubble); end
  endtask

  task automatic test_priority();
    logic [4:0] req_v [5] = '{5'b00010, 5'b01010, 5'b10000, 5'b00100, 5'b00000};
    logic [4:0] stl_v [5] = '{5'b00011, 5'b01111, 5'b11111, 5'b00111, 5'b00000};
    logic [4:0] bub_v [5] = '{5'b00100, 5'b10000, 5'b00000, 5'b01000, 5'b00000};
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      stall_req = req_v[i];
      #1;
      total++; if (stall !== stl_v[i]) begin bad++; $display("FAIL prio_stall[%0d] got=%b exp=%b", i, stall, stl_v[i]); end
      total++; if (bubble !== bub_v[i]) begin bad++; $display("FAIL prio_bubble[%0d] got=%b exp=%b", i, bubble, bub_v[i]); end
    end
    stall_req = '0;
  endtask

  task automatic test_mc_op(input int n);
    next_cycle();
    mc_start = 1'b1; mc_len = 6'(n);
    #1;
    if (n == 0) begin
      total++; if (stall !== 5'b0) begin bad++; $display("FAIL mc0_stall got=%b exp=00000", stall); end
      next_cycle(); #1;
      total++; if (mc_done !== 1'b0 || mc_busy !== 1'b0) begin bad++; $display("FAIL mc0_fsm got=%b%b exp=00", mc_busy, mc_done); end
      mc_start = 1'b0;
      return;
    end
    for (int c = 0; c < n; c++) begin
      if (c > 0) begin next_cycle(); #1; end
      total++; if (stall !== 5'b00111 || bubble !== 5'b01000) begin bad++; $display("FAIL mc%0d_stall c=%0d got=%b/%b exp=00111/01000", n, c, stall, bubble); end
      total++; if (mc_done !== 1'b0 || mc_busy !== (c > 0)) begin bad++; $display("FAIL mc%0d_fsm c=%0d got=%b%b exp=%b0", n, c, mc_busy, mc_done, c > 0); end
    end
    next_cycle(); #1;
    total++; if (mc_done !== 1'b1 || stall !== 5'b0 || mc_busy !== 1'b0) begin bad++; $display("FAIL mc%0d_done got=%b stall=%b busy=%b exp=1/00000/0", n, mc_done, stall, mc_busy); end
    next_cycle();
    mc_start = 1'b0;
    #1;
    total++; if (mc_done !== 1'b0 || stall !== 5'b0) begin bad++; $display("FAIL mc%0d_idle got=%b stall=%b exp=0/00000", n, mc_done, stall); end
  endtask

  task automatic test_flush();
    next_cycle();
    stall_req = 5'b00001; flush_req = 1'b1;
    #1;
    total++; if (stall !== 5'b0 || bubble !== 5'b00010) begin bad++; $display("FAIL flush_low got=%b/%b exp=00000/00010", stall, bubble); end
    next_cycle();
    stall_req = '0; flush_req = 1'b0;
    #1;
    total++; if (bubble !== 5'b0) begin bad++; $display("FAIL flush_nopend got=%b exp=00000", bubble); end
    next_cycle();
    stall_req = 5'b00100; flush_req = 1'b1;
    #1;
    total++; if (stall !== 5'b00111 || bubble !== 5'b01000) begin bad++; $display("FAIL flush_blocked got=%b/%b exp=00111/01000", stall, bubble); end
    next_cycle();
    stall_req = '0; flush_req = 1'b0;
    #1;
    total++; if (stall !== 5'b0 || bubble !== 5'b00010) begin bad++; $display("FAIL flush_pend_apply got=%b/%b exp=00000/00010", stall, bubble); end
    next_cycle(); #1;
    total++; if (bubble !== 5'b0) begin bad++; $display("FAIL flush_pend_clear got=%b exp=00000", bubble); end
  endtask

  task automatic test_flush_busy();
    next_cycle();
    mc_start = 1'b1; mc_len = 6'd3;
    next_cycle();
    flush_req = 1'b1;
    #1;
    total++; if (stall !== 5'b00111 || bubble !== 5'b01000) begin bad++; $display("FAIL fbusy_hold got=%b/%b exp=00111/01000", stall, bubble); end
    next_cycle();
    flush_req = 1'b0;
    #1;
    total++; if (mc_busy !== 1'b1 || bubble !== 5'b01000) begin bad++; $display("FAIL fbusy_stays got=%b/%b exp=1/01000", mc_busy, bubble); end
    next_cycle(); #1;
    total++; if (mc_done !== 1'b1 || bubble !== 5'b00010 || stall !== 5'b0) begin bad++; $display("FAIL fbusy_apply done=%b bubble=%b stall=%b exp=1/00010/00000", mc_done, bubble, stall); end
    next_cycle();
    mc_start = 1'b0;
    #1;
    total++; if (bubble !== 5'b0) begin bad++; $display("FAIL fbusy_clear got=%b exp=00000", bubble); end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    mc_start = 1'b1; mc_len = 6'd2;
    next_cycle();
    mc_len = 6'd60;
    #1;
    total++; if (stall !== 5'b00111 || mc_busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b/%b exp=00111/1", stall, mc_busy); end
    next_cycle(); #1;
    total++; if (mc_done !== 1'b1 || stall !== 5'b0) begin bad++; $display("FAIL b2b_len_ignored done=%b stall=%b exp=1/00000", mc_done, stall); end
    next_cycle();
    mc_len = 6'd2;
    #1;
    total++; if (stall !== 5'b00111 || mc_done !== 1'b0) begin bad++; $display("FAIL b2b_restart got=%b/%b exp=00111/0", stall, mc_done); end
    next_cycle(); #1;
    total++; if (stall !== 5'b00111 || mc_busy !== 1'b1) begin bad++; $display("FAIL b2b_second got=%b/%b exp=00111/1", stall, mc_busy); end
    next_cycle(); #1;
    total++; if (mc_done !== 1'b1) begin bad++; $display("FAIL b2b_done2 got=%b exp=1", mc_done); end
    next_cycle();
    mc_start = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int seen_done;
    next_cycle();
    mc_start = 1'b1; mc_len = 6'd10;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
    total++; if (stall !== 5'b0 || bubble !== 5'b0 || mc_busy !== 1'b0 || mc_done !== 1'b0) begin bad++; $display("FAIL midrst_outs got=%b/%b/%b/%b exp=0", stall, bubble, mc_busy, mc_done); end
    next_cycle();
    mc_start = 1'b0;
    rst = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 12; c++) begin
      next_cycle(); #1;
      if (mc_done !== 1'b0 || mc_busy !== 1'b0 || stall !== 5'b0) seen_done++;
    end
    total++; if (seen_done != 0) begin bad++; $display("FAIL midrst_idle got=%0d active cycles exp=0", seen_done); end
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic test_perf_cnt();
    next_cycle();
    cnt_clr = 1'b1;
    next_cycle();
    cnt_clr = 1'b0;
    #1;
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL cnt_clr got=%h exp=0", stall_cnt); end
    stall_req = 5'b00001;
    for (int c = 0; c < 7; c++) next_cycle();
    stall_req = '0;
    #1;
    total++; if (stall_cnt !== 32'd7) begin bad++; $display("FAIL cnt_seven got=%0d exp=7", stall_cnt); end
    stall_req = 5'b00001; cnt_clr = 1'b1;
    next_cycle();
    stall_req = '0; cnt_clr = 1'b0;
    #1;
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL cnt_clr_prio got=%h exp=0", stall_cnt); end
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt_q;
    stall_req = 5'b00001;
    for (int c = 0; c < 4; c++) next_cycle();
    stall_req = '0;
    #1;
    total++; if (stall_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cnt_sat got=%h exp=ffffffff", stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_priority();
    test_mc_op(4);
    test_mc_op(1);
    test_mc_op(0);
    test_flush();
    test_flush_busy();
    test_back_to_back();
    test_reset_mid_op();
`ifdef PIPE_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
